// File: rtl/id_stage.sv
// id_stage: instruction decode stage of a 5-stage MIPS-style pipeline.
// Holds the 32x32 register file (r0 hardwired to zero, write-through on
// same-cycle writeback), decodes the opcode into ID/EX control signals,
// detects load-use and branch-operand hazards (Stall), resolves beq/bne
// in ID and computes branch/jump targets and the PC select (PCSrc/Flush).
// Ports:
//   clk, reset                      clock, async active-high reset
//   Instruction, PCPlus4ID          IF/ID register contents
//   RegWriteWB/WriteRegWB/WriteDataWB  writeback port of the register file
//   MemReadEX/RegWriteEX/WriteRegEX, MemReadMEM/WriteRegMEM  hazard inputs
//   RegDst..ALUOp, ReadData*, ExtendedIm, ReadRegister*, Rt, Rd  to ID/EX
//   Stall, Flush, PCSrc, BranchTarget, JumpTarget  to the front end
// All outputs are combinational; every output is 0 while reset is high.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] PCPlus4ID,
  input  logic        RegWriteWB,
  input  logic [4:0]  WriteRegWB,
  input  logic [31:0] WriteDataWB,
  input  logic        MemReadEX,
  input  logic        RegWriteEX,
  input  logic [4:0]  WriteRegEX,
  input  logic        MemReadMEM,
  input  logic [4:0]  WriteRegMEM,
  output logic        RegDst,
  output logic        MemRead,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [1:0]  ALUOp,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] ExtendedIm,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic        Stall,
  output logic        Flush,
  output logic [1:0]  PCSrc,
  output logic [31:0] BranchTarget,
  output logic [31:0] JumpTarget
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [31:0] rf [32];
  logic        wr_blk;
  logic        wr_en;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rd1, rd2, sext;
  logic        is_r, is_lw, is_sw, is_addi, is_beq, is_bne, is_j, is_br;
  logic        uses_rt, load_use, br_stall, stall_i, taken;
  logic [7:0]  ctl;

  // Writes stay blocked until the first clk edge after reset releases, so a
  // write landing on the same edge as deassertion is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_blk <= 1'b1;
    else       wr_blk <= 1'b0;
  end

  assign wr_en = RegWriteWB && (WriteRegWB != 5'd0) && !wr_blk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[WriteRegWB] <= WriteDataWB;
    end
  end

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign sext   = {{16{Instruction[15]}}, Instruction[15:0]};

  // Write-through: a same-cycle writeback to the read index wins over the array.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != 5'd0) rd1 = (wr_en && WriteRegWB == rs) ? WriteDataWB : rf[rs];
    if (rt != 5'd0) rd2 = (wr_en && WriteRegWB == rt) ? WriteDataWB : rf[rt];
  end

  assign is_r    = (opcode == OP_RTYPE);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_addi = (opcode == OP_ADDI);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_j    = (opcode == OP_J);
  assign is_br   = is_beq || is_bne;
  assign uses_rt = is_r || is_sw || is_br;

  assign load_use = MemReadEX && (WriteRegEX != 5'd0) &&
                    ((WriteRegEX == rs) || (uses_rt && WriteRegEX == rt));
  // Branches compare in ID, so any in-flight producer of rs/rt must drain first.
  assign br_stall = is_br &&
                    ((RegWriteEX && (WriteRegEX != 5'd0) &&
                      (WriteRegEX == rs || WriteRegEX == rt)) ||
                     (MemReadMEM && (WriteRegMEM != 5'd0) &&
                      (WriteRegMEM == rs || WriteRegMEM == rt)));
  assign stall_i  = load_use || br_stall;
  assign taken    = (is_beq && rd1 == rd2) || (is_bne && rd1 != rd2);

  // ctl = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp}
  always_comb begin
    ctl = 8'b0000_0000;
    if (is_r)         ctl = 8'b1001_0010;
    else if (is_lw)   ctl = 8'b0111_1000;
    else if (is_sw)   ctl = 8'b0100_0100;
    else if (is_addi) ctl = 8'b0101_0000;
    else if (is_br)   ctl = 8'b0000_0001;
  end

  always_comb begin
    RegDst = 1'b0; ALUSrc = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; ALUOp = 2'b00;
    ReadData1 = '0; ReadData2 = '0; ExtendedIm = '0;
    ReadRegister1 = '0; ReadRegister2 = '0; Rt = '0; Rd = '0;
    Stall = 1'b0; Flush = 1'b0; PCSrc = 2'b00;
    BranchTarget = '0; JumpTarget = '0;
    if (!reset) begin
      ReadData1     = rd1;
      ReadData2     = rd2;
      ExtendedIm    = sext;
      ReadRegister1 = rs;
      ReadRegister2 = rt;
      Rt            = rt;
      Rd            = rd;
      BranchTarget  = PCPlus4ID + {sext[29:0], 2'b00};
      JumpTarget    = {PCPlus4ID[31:28], Instruction[25:0], 2'b00};
      Stall         = stall_i;
      if (!stall_i) begin
        {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp} = ctl;
        if (taken) begin
          PCSrc = 2'b01;
          Flush = 1'b1;
        end else if (is_j) begin
          PCSrc = 2'b10;
          Flush = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: register file, decode, hazards, PC select.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction, PCPlus4ID, WriteDataWB;
  logic        RegWriteWB, MemReadEX, RegWriteEX, MemReadMEM;
  logic [4:0]  WriteRegWB, WriteRegEX, WriteRegMEM;
  logic        RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [1:0]  ALUOp, PCSrc;
  logic [31:0] ReadData1, ReadData2, ExtendedIm, BranchTarget, JumpTarget;
  logic [4:0]  ReadRegister1, ReadRegister2, Rt, Rd;
  logic        Stall, Flush;

  int n_checks = 0;
  int n_errors = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .PCPlus4ID(PCPlus4ID),
    .RegWriteWB(RegWriteWB), .WriteRegWB(WriteRegWB), .WriteDataWB(WriteDataWB),
    .MemReadEX(MemReadEX), .RegWriteEX(RegWriteEX), .WriteRegEX(WriteRegEX),
    .MemReadMEM(MemReadMEM), .WriteRegMEM(WriteRegMEM),
    .RegDst(RegDst), .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ExtendedIm(ExtendedIm),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .Rt(Rt), .Rd(Rd),
    .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .JumpTarget(JumpTarget)
  );

  always #5 clk = ~clk;

  // {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp}
  function automatic logic [31:0] ctl_vec();
    return {24'd0, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Performs one writeback on the next rising edge, then releases the port.
  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    RegWriteWB = 1'b1; WriteRegWB = r; WriteDataWB = d;
    @(negedge clk);
    RegWriteWB = 1'b0; WriteRegWB = '0; WriteDataWB = '0;
  endtask

  initial begin
    reset = 1'b1;
    Instruction = {6'd0, 5'd8, 5'd2, 5'd9, 5'd0, 6'h20};
    PCPlus4ID = 32'h0000_0010;
    RegWriteWB = 1'b0; WriteRegWB = '0; WriteDataWB = '0;
    MemReadEX = 1'b1; RegWriteEX = 1'b0; WriteRegEX = 5'd8;
    MemReadMEM = 1'b0; WriteRegMEM = '0;
    #2;
    check("rst_ctl", ctl_vec(), 32'h0);
    check("rst_stall", {31'd0, Stall}, 32'h0);
    check("rst_rd", {27'd0, Rd}, 32'h0);
    check("rst_ext", ExtendedIm, 32'h0);
    @(negedge clk); reset = 1'b0; MemReadEX = 1'b0; WriteRegEX = '0;
    @(negedge clk);

    // All registers zero after reset; unknown opcode decodes to all-zero controls.
    for (int i = 1; i < 32; i++) begin
      Instruction = {6'b111111, 5'(i), 5'(i), 16'd0};
      #1;
      check($sformatf("zero_rd1_r%0d", i), ReadData1, 32'h0);
      check($sformatf("zero_rd2_r%0d", i), ReadData2, 32'h0);
      check($sformatf("zero_ctl_r%0d", i), ctl_vec(), 32'h0);
    end

    // Write-through of r5 in the same cycle, then persistence.
    @(negedge clk);
    Instruction = {6'd0, 5'd5, 5'd0, 5'd0, 11'd0};
    RegWriteWB = 1'b1; WriteRegWB = 5'd5; WriteDataWB = 32'hDEAD_BEEF;
    #1 check("wt_r5", ReadData1, 32'hDEAD_BEEF);
    @(negedge clk);
    RegWriteWB = 1'b0; WriteRegWB = '0; WriteDataWB = '0;
    #1 check("persist_r5", ReadData1, 32'hDEAD_BEEF);

    // r0 ignores writes.
    @(negedge clk);
    Instruction = {6'd0, 5'd0, 5'd0, 5'd0, 11'd0};
    RegWriteWB = 1'b1; WriteRegWB = 5'd0; WriteDataWB = 32'h1234;
    #1 check("wt_r0", ReadData1, 32'h0);
    @(negedge clk);
    RegWriteWB = 1'b0; WriteDataWB = '0;
    #1 check("r0_after", ReadData1, 32'h0);
    check("nop_ctl", ctl_vec(), 32'h92);

    // Load-use hazard on add r9,r8,r2.
    Instruction = {6'd0, 5'd8, 5'd2, 5'd9, 5'd0, 6'h20};
    MemReadEX = 1'b1; WriteRegEX = 5'd8;
    #1 check("lu_stall", {31'd0, Stall}, 32'h1);
    check("lu_bubble", ctl_vec(), 32'h0);
    check("lu_flush", {31'd0, Flush}, 32'h0);
    @(negedge clk);
    MemReadEX = 1'b0;
    #1 check("lu_clear", {31'd0, Stall}, 32'h0);
    check("add_ctl", ctl_vec(), 32'h92);
    check("add_rd", {27'd0, Rd}, 32'd9);
    // Load dest matching rt of rs-only lw does not stall.
    Instruction = {6'b100011, 5'd3, 5'd8, 16'h0004};
    MemReadEX = 1'b1; WriteRegEX = 5'd8;
    #1 check("lw_rt_nostall", {31'd0, Stall}, 32'h0);
    check("lw_ctl", ctl_vec(), 32'h78);
    // r0 as load destination never stalls.
    Instruction = {6'd0, 5'd0, 5'd0, 5'd9, 11'h20};
    WriteRegEX = 5'd0;
    #1 check("lu_r0", {31'd0, Stall}, 32'h0);
    MemReadEX = 1'b0;

    // sw decode with negative immediate; addi decode.
    Instruction = {6'b101011, 5'd1, 5'd2, 16'h8000};
    #1 check("sw_ctl", ctl_vec(), 32'h44);
    check("sw_ext", ExtendedIm, 32'hFFFF_8000);
    Instruction = {6'b001000, 5'd1, 5'd2, 16'h7FFF};
    #1 check("addi_ctl", ctl_vec(), 32'h50);
    check("addi_ext", ExtendedIm, 32'h0000_7FFF);

    // beq r1,r2,-1 with r1=r2=7.
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    Instruction = {6'b000100, 5'd1, 5'd2, 16'hFFFF};
    PCPlus4ID = 32'h0000_0010;
    #1 check("beq_pcsrc", {30'd0, PCSrc}, 32'h1);
    check("beq_target", BranchTarget, 32'h0000_000C);
    check("beq_flush", {31'd0, Flush}, 32'h1);
    check("beq_ctl", ctl_vec(), 32'h01);
    RegWriteEX = 1'b1; WriteRegEX = 5'd2;
    #1 check("beq_ex_stall", {31'd0, Stall}, 32'h1);
    check("beq_ex_flush", {31'd0, Flush}, 32'h0);
    check("beq_ex_pcsrc", {30'd0, PCSrc}, 32'h0);
    check("beq_ex_ctl", ctl_vec(), 32'h0);
    RegWriteEX = 1'b0; WriteRegEX = '0;
    MemReadMEM = 1'b1; WriteRegMEM = 5'd1;
    #1 check("beq_mem_stall", {31'd0, Stall}, 32'h1);
    MemReadMEM = 1'b0; WriteRegMEM = '0;
    // bne with equal operands is not taken.
    Instruction = {6'b000101, 5'd1, 5'd2, 16'h0003};
    #1 check("bne_nt_pcsrc", {30'd0, PCSrc}, 32'h0);
    check("bne_nt_flush", {31'd0, Flush}, 32'h0);
    check("bne_target", BranchTarget, 32'h0000_001C);
    // bne r1,r5 (7 vs DEADBEEF) is taken.
    Instruction = {6'b000101, 5'd1, 5'd5, 16'h0003};
    #1 check("bne_t_pcsrc", {30'd0, PCSrc}, 32'h1);
    // beq with differing operands is not taken.
    Instruction = {6'b000100, 5'd1, 5'd5, 16'h0003};
    #1 check("beq_nt_pcsrc", {30'd0, PCSrc}, 32'h0);
    // Target wraps modulo 2^32.
    Instruction = {6'b000100, 5'd1, 5'd2, 16'h0001};
    PCPlus4ID = 32'hFFFF_FFFC;
    #1 check("beq_wrap", BranchTarget, 32'h0000_0000);

    // Jump.
    Instruction = {6'b000010, 26'h000_0100};
    PCPlus4ID = 32'hA000_0004;
    #1 check("j_target", JumpTarget, 32'hA000_0400);
    check("j_pcsrc", {30'd0, PCSrc}, 32'h2);
    check("j_flush", {31'd0, Flush}, 32'h1);
    check("j_ctl", ctl_vec(), 32'h0);

    // Async reset clears r3 without any clk edge.
    wb_write(5'd3, 32'h0000_0055);
    Instruction = {6'd0, 5'd3, 5'd0, 5'd0, 11'd0};
    #1 check("r3_written", ReadData1, 32'h0000_0055);
    #1 reset = 1'b1;
    #1 check("rst_mid_out", ReadData1, 32'h0);
    #1 reset = 1'b0;
    #1 check("r3_cleared", ReadData1, 32'h0);
    check("r5_cleared", 32'(dut.rf[5]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
REQ-002 Inputs SHALL be:
- Instruction  in  32  IF/ID instruction
- PCPlus4ID  in  32  IF/ID PC+4
- RegWriteWB  in  1  writeback enable
- WriteRegWB  in  5  writeback destination register
- WriteDataWB  in  32  writeback data
- MemReadEX  in  1  EX-stage load flag
- RegWriteEX  in  1  EX-stage write flag
- WriteRegEX  in  5  EX-stage destination register (post RegDst mux)
- MemReadMEM  in  1  MEM-stage load flag
- WriteRegMEM  in  5  MEM-stage destination register
REQ-003 Outputs feeding the ID/EX register SHALL be:
- RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1 each  control
- ALUOp  out  2  ALU operation class
- ReadData1, ReadData2, ExtendedIm  out  32 each
- ReadRegister1, ReadRegister2, Rt, Rd  out  5 each
REQ-004 Control outputs to the front end SHALL be:
- Stall  out  1  hold PC and IF/ID
- Flush  out  1  clear IF/ID
- PCSrc  out  2  PC select: 00 = PC+4, 01 = branch, 10 = jump
- BranchTarget  out  32
- JumpTarget  out  32

Function
REQ-005 The block SHALL hold a 32x32 register file; register 0 SHALL read 0 and ignore writes.
REQ-006 The register file SHALL write WriteDataWB to WriteRegWB on the rising clk edge when RegWriteWB=1 and WriteRegWB!=0.
REQ-007 Reads SHALL be combinational, with write-through: if RegWriteWB=1, WriteRegWB!=0 and WriteRegWB equals the read index, the read SHALL return WriteDataWB in the same cycle.
REQ-008 Field mapping: ReadRegister1=Instruction[25:21], ReadRegister2=Rt=Instruction[20:16], Rd=Instruction[15:11].
REQ-009 ExtendedIm SHALL equal Instruction[15:0] sign-extended to 32 bits.
REQ-010 Decode by opcode, giving RegDst/ALUSrc/MemtoReg/RegWrite/MemRead/MemWrite/ALUOp:
- R-type 000000: 1/0/0/1/0/0/10
- lw 100011: 0/1/1/1/1/0/00
- sw 101011: x->0/1/0/0/0/1/00
- addi 001000: 0/1/0/1/0/0/00
- beq 000100 and bne 000101: 0/0/0/0/0/0/01
- j 000010: all 0
- any other opcode: all controls 0 (nop).
REQ-011 Instruction=32'h00000000 SHALL decode as R-type with Rd=0, which is architecturally a nop.
REQ-012 Load-use stall: Stall SHALL be 1 when MemReadEX=1, WriteRegEX!=0 and WriteRegEX equals rs or rt; rt SHALL be compared only for R-type, sw, beq and bne.
REQ-013 Branch stall: for beq/bne, Stall SHALL be 1 in either case:
- RegWriteEX=1, WriteRegEX!=0 and WriteRegEX matches rs or rt
- MemReadMEM=1, WriteRegMEM!=0 and WriteRegMEM matches rs or rt
REQ-014 While Stall=1, all REQ-010 control outputs SHALL be forced to 0 (bubble), and PCSrc=00 and Flush=0.
REQ-015 Branch resolution SHALL use the REQ-007 read values: beq is taken iff ReadData1==ReadData2, and bne is taken iff they differ.
REQ-016 BranchTarget SHALL equal PCPlus4ID + (ExtendedIm<<2), modulo 2^32 (wrap-around, no overflow flag).
REQ-017 JumpTarget SHALL equal {PCPlus4ID[31:28], Instruction[25:0], 2'b00}.
REQ-018 PC selection, when not stalled:
- taken branch: PCSrc=01 and Flush=1
- j: PCSrc=10 and Flush=1
- otherwise: PCSrc=00 and Flush=0
REQ-019 Stall and Flush SHALL never be 1 simultaneously.
REQ-020 All outputs SHALL be combinational in the current inputs and register-file state; the only storage SHALL be the register file, so latency is 0 cycles.

Reset
REQ-021 Asserting reset SHALL immediately and asynchronously clear all 32 registers to 0.
REQ-022 While reset=1, every output SHALL be 0 and writes SHALL be blocked.
REQ-023 Deasserting reset SHALL resume normal operation on the next rising clk edge; a write coincident with reset deassertion SHALL be ignored.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios:
- Reset, then read r1..r31 -> every ReadData is 0 and every control output is 0.
- Write r5=32'hDEADBEEF via WB while reading rs=5 in the same cycle -> ReadData1=32'hDEADBEEF that cycle and after.
- Write to r0=32'h1234, then read rs=0 -> ReadData1=0.
- lw r8 in EX (MemReadEX=1, WriteRegEX=8), ID holds add r9,r8,r2 -> Stall=1 and all controls 0; with MemReadEX=0 next cycle -> Stall=0 and add controls valid (RegDst=1, ALUOp=10).
- beq r1,r2,-1 with r1=r2=7 at PCPlus4ID=32'h00000010 -> PCSrc=01, BranchTarget=32'h0000000C, Flush=1.
- Same beq with RegWriteEX=1, WriteRegEX=2 -> Stall=1, Flush=0, PCSrc=00.
- j 26'h0000100 at PCPlus4ID=32'hA0000004 -> JumpTarget=32'hA0000400, PCSrc=10, Flush=1.
- Reset asserted mid-cycle after r3 was written -> r3 reads 0 immediately, with no clk edge required.
